// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage. Owns the word-addressed PC, presents it to a
//   combinational instruction memory and registers the returned word plus its
//   PC into the IF/ID pipeline register. Sits in IDLE after reset until start,
//   then fetches every cycle, honouring redirect (highest priority) and stall.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   start          IDLE -> RUN
//   stall          hold PC and IF/ID (RUN only)
//   redirect       load redirect_pc (mod IMEM_DEPTH), squash IF/ID (RUN only)
//   redirect_pc    redirect target, word address
//   imem_addr      word address to instruction memory (copy of PC)
//   imem_data      instruction for imem_addr, combinational
//   if_id_instr    registered instruction
//   if_id_pc       PC of if_id_instr
//   if_id_valid    if_id_instr is a real fetched instruction
//   running        FSM is in RUN
//   fetch_count    saturating count of captured instructions
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int IMEM_DEPTH = 256,
    parameter int RESET_PC   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        running,
    output logic [15:0] fetch_count
);

    localparam int            AW     = $clog2(IMEM_DEPTH);
    localparam logic [AW-1:0] PC_RST = AW'(RESET_PC);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_inc;

    // Redirect target bits above the memory index are dropped (mod depth).
    logic unused_redirect_hi;
    assign unused_redirect_hi = ^redirect_pc[31:AW];

    // Power-of-two depth: natural AW-bit overflow gives the modulo wrap.
    assign pc_inc = pc + AW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= PC_RST;
            if_id_instr <= 32'h0;
            if_id_pc    <= 32'h0;
            if_id_valid <= 1'b0;
            fetch_count <= 16'h0;
        end else if (state == RUN) begin
            if (redirect) begin
                // Squash the word fetched this cycle; it is on the wrong path.
                pc          <= redirect_pc[AW-1:0];
                if_id_instr <= 32'h0;
                if_id_pc    <= 32'h0;
                if_id_valid <= 1'b0;
            end else if (!stall) begin
                pc          <= pc_inc;
                if_id_instr <= imem_data;
                if_id_pc    <= {{(32-AW){1'b0}}, pc};
                if_id_valid <= 1'b1;
                if (fetch_count != 16'hFFFF)
                    fetch_count <= fetch_count + 16'd1;
            end
        end
    end

    assign imem_addr = {{(32-AW){1'b0}}, pc};
    assign running   = (state == RUN);

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage (IMEM_DEPTH=256, RESET_PC=0). A small
//   combinational memory model returns a per-address pattern (address 3 holds
//   a NOP). Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        running;
    logic [15:0] fetch_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage #(.IMEM_DEPTH(256), .RESET_PC(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .running     (running),
        .fetch_count (fetch_count)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'd3) ? 32'h0 : (32'hC0DE_0000 | (a & 32'hFF));
    endfunction

    assign imem_data = mem(imem_addr);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks a normal capture of address a with the resulting count.
    task automatic chk_cap(input string tag, input logic [31:0] a, input logic [31:0] cnt);
        check({tag, " pc"},    if_id_pc, a);
        check({tag, " instr"}, if_id_instr, mem(a));
        check({tag, " vld"},   {31'h0, if_id_valid}, 32'd1);
        check({tag, " cnt"},   {16'h0, fetch_count}, cnt);
        check({tag, " addr"},  imem_addr, (a + 32'd1) & 32'hFF);
    endtask

    task automatic chk_squash(input string tag, input logic [31:0] tgt, input logic [31:0] cnt);
        check({tag, " addr"},  imem_addr, tgt);
        check({tag, " vld"},   {31'h0, if_id_valid}, 32'd0);
        check({tag, " instr"}, if_id_instr, 32'h0);
        check({tag, " cnt"},   {16'h0, fetch_count}, cnt);
    endtask

    initial begin
        // Reset state, before any edge.
        #2;
        check("rst addr",  imem_addr, 32'h0);
        check("rst vld",   {31'h0, if_id_valid}, 32'd0);
        check("rst run",   {31'h0, running}, 32'd0);
        check("rst cnt",   {16'h0, fetch_count}, 32'd0);
        step();
        rst = 1'b0;

        // IDLE ignores redirect and stall.
        redirect = 1'b1; redirect_pc = 32'd77; stall = 1'b1;
        step();
        check("idle addr", imem_addr, 32'h0);
        check("idle run",  {31'h0, running}, 32'd0);
        check("idle vld",  {31'h0, if_id_valid}, 32'd0);
        redirect = 1'b0; stall = 1'b0;

        // Start: running after edge N, first capture at N+1.
        start = 1'b1;
        step();
        start = 1'b0;
        check("start run", {31'h0, running}, 32'd1);
        check("start vld", {31'h0, if_id_valid}, 32'd0);
        check("start addr", imem_addr, 32'h0);

        // Five sequential fetches (address 3 is a NOP, still counted).
        for (int k = 0; k < 5; k++) begin
            step();
            chk_cap("seq", k, k + 1);
        end

        // Stall 3 cycles at PC=5.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall addr", imem_addr, 32'd5);
            check("stall pc",   if_id_pc, 32'd4);
            check("stall cnt",  {16'h0, fetch_count}, 32'd5);
        end
        stall = 1'b0;
        step();
        chk_cap("post stall", 5, 6);

        // Advance to PC=14; start asserted in RUN must have no effect.
        start = 1'b1;
        for (int k = 6; k < 14; k++) begin
            step();
            chk_cap("adv", k, k + 1);
        end
        start = 1'b0;

        // Redirect at PC=14 to 18; 15 never captured.
        redirect = 1'b1; redirect_pc = 32'd18;
        step();
        redirect = 1'b0;
        chk_squash("redir", 32'd18, 32'd14);
        step();
        chk_cap("redir tgt", 18, 15);

        // Stall and redirect together: redirect wins.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'd44;
        step();
        stall = 1'b0; redirect = 1'b0;
        chk_squash("st+redir", 32'd44, 32'd15);
        step();
        chk_cap("st+redir tgt", 44, 16);

        // Wrap 255 -> 0.
        redirect = 1'b1; redirect_pc = 32'd255;
        step();
        redirect = 1'b0;
        chk_squash("to255", 32'd255, 32'd16);
        step();
        chk_cap("cap255", 255, 17);
        step();
        chk_cap("wrap0", 0, 18);

        // Redirect target 300 reduces to 44.
        redirect = 1'b1; redirect_pc = 32'd300;
        step();
        redirect = 1'b0;
        chk_squash("mod300", 32'd44, 32'd18);
        step();
        chk_cap("mod300 tgt", 44, 19);

        // Asynchronous reset mid-run at PC=20.
        redirect = 1'b1; redirect_pc = 32'd20;
        step();
        redirect = 1'b0;
        check("pre rst addr", imem_addr, 32'd20);
        #2;
        rst = 1'b1;
        #1;
        check("arst addr",  imem_addr, 32'h0);
        check("arst run",   {31'h0, running}, 32'd0);
        check("arst cnt",   {16'h0, fetch_count}, 32'd0);
        check("arst instr", if_id_instr, 32'h0);
        check("arst pc",    if_id_pc, 32'h0);
        check("arst vld",   {31'h0, if_id_valid}, 32'd0);
        step();
        rst = 1'b0;
        step();
        check("post rst idle", {31'h0, running}, 32'd0);
        check("post rst addr", imem_addr, 32'h0);

        // Restart and run long enough to saturate the counter.
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart run", {31'h0, running}, 32'd1);
        step();
        chk_cap("restart cap", 0, 1);
        repeat (65540) @(posedge clk);
        #1;
        check("sat cnt", {16'h0, fetch_count}, 32'h0000_FFFF);
        step();
        check("sat hold", {16'h0, fetch_count}, 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
